// File: rtl/mac_pkg.sv
// Shared MAC datapath helpers: Wallace-tree sizing and multiplier latency.
// All functions are elaboration-time constants for the pipeline generators.
package mac_pkg;

  localparam int MAC_DEFAULT_WIDTH = 16;
  localparam int MAC_DEFAULT_ROWS  = MAC_DEFAULT_WIDTH + 1;

  // W partial-product rows plus the signed correction row
  function automatic int mul_rows(input int w);
    return w + 1;
  endfunction

  function automatic int csa_rows_next(input int rows);
    return 2 * (rows / 3) + (rows % 3);
  endfunction

  function automatic int csa_rows_at(input int rows, input int level);
    int n;
    n = rows;
    for (int i = 0; i < level; i++) n = csa_rows_next(n);
    return n;
  endfunction

  function automatic int csa_levels(input int rows);
    int n;
    int l;
    n = rows;
    l = 0;
    while (n > 2) begin
      n = csa_rows_next(n);
      l++;
    end
    return l;
  endfunction

  function automatic int mul_latency(input int w, input int lps);
    return 3 + (csa_levels(mul_rows(w)) + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/mac_csa.sv
// 3:2 carry-save compressor; carry is returned unshifted (weight of bit i is 2^(i+1)).
module mac_csa #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] carry_o
);

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/mac_mul_pipe.sv
// Pipelined Wallace-tree multiplier, signed/unsigned per op, tag sideband,
// global-stall valid/ready handshake and synchronous flush.
module mac_mul_pipe
  import mac_pkg::*;
#(
  parameter int INPUT_WIDTH      = 16,
  parameter int OUTPUT_WIDTH     = 2 * INPUT_WIDTH,
  parameter int TAG_WIDTH        = 4,
  parameter int LEVELS_PER_STAGE = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic [INPUT_WIDTH-1:0]  i_mul_a,
  input  logic [INPUT_WIDTH-1:0]  i_mul_b,
  input  logic                    i_mul_signed,
  input  logic [TAG_WIDTH-1:0]    i_mul_tag,
  input  logic                    i_mul_valid,
  output logic                    o_mul_ready,
  output logic [OUTPUT_WIDTH-1:0] o_mul_val,
  output logic [TAG_WIDTH-1:0]    o_mul_tag,
  output logic                    o_mul_valid,
  input  logic                    i_out_ready,
  output logic                    o_busy
);

  localparam int W    = INPUT_WIDTH;
  localparam int OW   = OUTPUT_WIDTH;
  localparam int ROWS = mul_rows(W);
  localparam int L    = csa_levels(ROWS);
  localparam int LAT  = mul_latency(W, LEVELS_PER_STAGE);

  typedef logic [OW-1:0] row_t;

  logic                 advance;
  logic [LAT-1:0]       vld_q, vld_d;
  logic [TAG_WIDTH-1:0] tag_q [LAT];
  logic [W-1:0]         a_q, b_q;
  logic                 sgn_q;
  row_t                 pp_d [ROWS];
  row_t                 pp_q [ROWS];
  row_t                 lvl_in [L+1][ROWS];
  row_t                 lvl_cmb [1:L][ROWS];
  row_t                 prod_q;

  assign advance     = !vld_q[LAT-1] || i_out_ready;
  assign o_mul_ready = advance;
  assign o_mul_valid = vld_q[LAT-1];
  assign o_mul_val   = prod_q;
  assign o_mul_tag   = tag_q[LAT-1];
  assign o_busy      = |vld_q;
  assign vld_d       = {vld_q[LAT-2:0], i_mul_valid};

  // Flush wins over stall so a frozen output is also discarded.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        vld_q <= '0;
    else if (i_flush) vld_q <= '0;
    else if (advance) vld_q <= vld_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else if (advance) begin
      a_q      <= i_mul_a;
      b_q      <= i_mul_b;
      sgn_q    <= i_mul_signed;
      tag_q[0] <= i_mul_tag;
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Signed mode: top row is inverted and a +1 correction row completes its negation.
  always_comb begin
    row_t a_ext;
    row_t row;
    a_ext = sgn_q ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
    row   = '0;
    for (int i = 0; i < W; i++) begin
      row   = b_q[i] ? (a_ext << i) : '0;
      pp_d[i] = (i == W - 1 && sgn_q) ? ~row : row;
    end
    pp_d[W] = {{(OW-1){1'b0}}, sgn_q};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        for (int r = 0; r < ROWS; r++) pp_q[r] <= '0;
    else if (advance) for (int r = 0; r < ROWS; r++) pp_q[r] <= pp_d[r];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lvl0
    assign lvl_in[0][r] = pp_q[r];
  end

  for (genvar l = 0; l < L; l++) begin : g_level
    localparam int N  = csa_rows_at(ROWS, l);
    localparam int NG = N / 3;
    localparam int NN = csa_rows_at(ROWS, l + 1);

    for (genvar g = 0; g < NG; g++) begin : g_csa
      row_t carry;
      mac_csa #(.WIDTH(OW)) u_csa (
        .a_i    (lvl_in[l][3*g]),
        .b_i    (lvl_in[l][3*g+1]),
        .c_i    (lvl_in[l][3*g+2]),
        .sum_o  (lvl_cmb[l+1][2*g]),
        .carry_o(carry)
      );
      assign lvl_cmb[l+1][2*g+1] = carry << 1;
    end

    for (genvar j = 0; j < N - 3 * NG; j++) begin : g_pass
      assign lvl_cmb[l+1][2*NG+j] = lvl_in[l][3*NG+j];
    end

    for (genvar r = NN; r < ROWS; r++) begin : g_unused
      assign lvl_cmb[l+1][r] = '0;
    end

    if (((l + 1) % LEVELS_PER_STAGE == 0) || (l + 1 == L)) begin : g_reg
      row_t rows_q [NN];
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        for (int r = 0; r < NN; r++) rows_q[r] <= '0;
        else if (advance) for (int r = 0; r < NN; r++) rows_q[r] <= lvl_cmb[l+1][r];
      end
      for (genvar r = 0; r < ROWS; r++) begin : g_out
        if (r < NN) begin : g_live
          assign lvl_in[l+1][r] = rows_q[r];
        end else begin : g_zero
          assign lvl_in[l+1][r] = '0;
        end
      end
    end else begin : g_comb
      for (genvar r = 0; r < ROWS; r++) begin : g_out
        assign lvl_in[l+1][r] = lvl_cmb[l+1][r];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        prod_q <= '0;
    else if (advance) prod_q <= lvl_in[L][0] + lvl_in[L][1];
  end

endmodule

// File: tb/tb_mac_mul_pipe.sv
// Bench for mac_mul_pipe: W=16/LPS=2 main instance plus W=8 at LPS 1, 2, 4,
// each checked every cycle against an in-order queue model with plain arithmetic products.
module tb_mac_mul_pipe;

  localparam int NDUT = 4;

  typedef struct {
    logic [31:0] val;
    logic [3:0]  tag;
    int          stamp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] a_s     [NDUT];
  logic [15:0] b_s     [NDUT];
  logic        sgn_s   [NDUT];
  logic [3:0]  tin_s   [NDUT];
  logic        vin_s   [NDUT];
  logic        flush_s [NDUT];
  logic        ordy_s  [NDUT];

  int errors = 0;
  int checks = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input bit s);
    longint sa, sb, p, mask;
    mask = (longint'(1) << w) - 1;
    sa = longint'(a) & mask;
    sb = longint'(b) & mask;
    if (s && sa[w-1]) sa -= longint'(1) << w;
    if (s && sb[w-1]) sb -= longint'(1) << w;
    p = sa * sb;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int W       = (g == 0) ? 16 : 8;
    localparam int LPS     = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 2 : 4;
    localparam int LAT_EXP = (g == 0) ? 6 : (g == 1) ? 7 : (g == 2) ? 5 : 4;

    logic [2*W-1:0] val;
    logic [3:0]     tout;
    logic           vout, rdy, busy;
    exp_t           q[$];
    int             adv_cnt = 0;

    mac_mul_pipe #(
      .INPUT_WIDTH(W), .OUTPUT_WIDTH(2 * W), .TAG_WIDTH(4), .LEVELS_PER_STAGE(LPS)
    ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_flush     (flush_s[g]),
      .i_mul_a     (a_s[g][W-1:0]),
      .i_mul_b     (b_s[g][W-1:0]),
      .i_mul_signed(sgn_s[g]),
      .i_mul_tag   (tin_s[g]),
      .i_mul_valid (vin_s[g]),
      .o_mul_ready (rdy),
      .o_mul_val   (val),
      .o_mul_tag   (tout),
      .o_mul_valid (vout),
      .i_out_ready (ordy_s[g]),
      .o_busy      (busy)
    );

    initial begin
      #3;
      check(val == 0,   $sformatf("d%0d reset_val", g), 64'(val), 0);
      check(tout == 0,  $sformatf("d%0d reset_tag", g), 64'(tout), 0);
      check(vout === 0, $sformatf("d%0d reset_valid", g), 64'(vout), 0);
      check(busy === 0, $sformatf("d%0d reset_busy", g), 64'(busy), 0);
      check(rdy === 1,  $sformatf("d%0d reset_ready", g), 64'(rdy), 1);
    end

    always @(negedge clk) begin
      exp_t e;
      logic adv;
      if (rst) begin
        q.delete();
      end else begin
        adv = !vout || ordy_s[g];
        check(rdy === adv, $sformatf("d%0d ready", g), 64'(rdy), 64'(adv));
        check(busy === (q.size() != 0), $sformatf("d%0d busy", g), 64'(busy),
              64'(q.size() != 0));
        if (vout && ordy_s[g]) begin
          if (q.size() == 0) begin
            check(1'b0, $sformatf("d%0d unexpected_output", g), 64'(val), 0);
          end else begin
            e = q.pop_front();
            check(val === e.val[2*W-1:0], $sformatf("d%0d product", g), 64'(val),
                  64'(e.val[2*W-1:0]));
            check(tout === e.tag, $sformatf("d%0d tag", g), 64'(tout), 64'(e.tag));
            check(adv_cnt - e.stamp == LAT_EXP, $sformatf("d%0d latency", g),
                  64'(adv_cnt - e.stamp), 64'(LAT_EXP));
          end
        end
        if (flush_s[g]) begin
          q.delete();
        end else if (vin_s[g] && adv) begin
          e.val   = ref_mul(W, a_s[g], b_s[g], sgn_s[g]);
          e.tag   = tin_s[g];
          e.stamp = adv_cnt;
          q.push_back(e);
        end
        if (adv) adv_cnt++;
      end
    end
  end

  task automatic timed_op(input logic [15:0] a, input logic [15:0] b, input bit s,
                          input logic [3:0] tag, input logic [31:0] exp, input string name);
    int n;
    a_s[0] = a; b_s[0] = b; sgn_s[0] = s; tin_s[0] = tag; vin_s[0] = 1'b1;
    @(posedge clk); #1;
    vin_s[0] = 1'b0;
    n = 1;
    while (!g_dut[0].vout && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(n == 6, {name, " cycles"}, 64'(n), 6);
    check(g_dut[0].val === exp, {name, " value"}, 64'(g_dut[0].val), 64'(exp));
    check(g_dut[0].tout === tag, {name, " tag"}, 64'(g_dut[0].tout), 64'(tag));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   cyc, stall_seen, seen;
    logic [15:0] bvals [10];
    bvals = '{16'h00, 16'h01, 16'h02, 16'h55, 16'h7F, 16'h80, 16'h81, 16'hAA, 16'hFE, 16'hFF};

    for (int g = 0; g < NDUT; g++) begin
      a_s[g] = '0; b_s[g] = '0; sgn_s[g] = 1'b0; tin_s[g] = '0;
      vin_s[g] = 1'b0; flush_s[g] = 1'b0; ordy_s[g] = 1'b1;
    end

    check(ref_mul(16, 16'hFFFF, 16'hFFFF, 0) == 32'hFFFE0001, "model_uu", 0, 0);
    check(ref_mul(16, 16'hFFFF, 16'h0002, 1) == 32'hFFFFFFFE, "model_s1", 0, 0);
    check(ref_mul(16, 16'h8000, 16'h7FFF, 1) == 32'hC0008000, "model_s2", 0, 0);
    check(ref_mul(8, 16'h0080, 16'h0080, 1) == 32'h00004000, "model_s8", 0, 0);

    #1 rst = 1'b1;
    #21 rst = 1'b0;
    @(posedge clk); #1;

    timed_op(16'hFFFF, 16'hFFFF, 1'b0, 4'h3, 32'hFFFE0001, "uns_ffff");
    timed_op(16'hFFFF, 16'h0002, 1'b1, 4'h5, 32'hFFFFFFFE, "sgn_m1x2");
    timed_op(16'h8000, 16'h7FFF, 1'b1, 4'h6, 32'hC0008000, "sgn_minxmax");
    timed_op(16'h8000, 16'h8000, 1'b1, 4'h7, 32'h40000000, "sgn_minxmin");

    // back-to-back random stream with a 3-cycle downstream stall
    cyc = 0;
    stall_seen = 0;
    for (int i = 0; i < 64; i++) begin
      a_s[0] = 16'($urandom); b_s[0] = 16'($urandom);
      sgn_s[0] = 1'($urandom_range(0, 1)); tin_s[0] = 4'(i); vin_s[0] = 1'b1;
      do begin
        ordy_s[0] = !(cyc >= 20 && cyc < 23);
        @(negedge clk);
        acc = g_dut[0].rdy;
        if (!acc) stall_seen++;
        @(posedge clk); #1;
        cyc++;
      end while (!acc);
    end
    vin_s[0] = 1'b0;
    ordy_s[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check(stall_seen == 3, "stall_ready_low_cycles", 64'(stall_seen), 3);
    check(g_dut[0].q.size() == 0, "stream_drained", 64'(g_dut[0].q.size()), 0);

    // flush with four in flight; an input alongside the flush must be dropped
    for (int i = 0; i < 4; i++) begin
      a_s[0] = 16'(i + 1); b_s[0] = 16'h0101; sgn_s[0] = 1'b0;
      tin_s[0] = 4'(8 + i); vin_s[0] = 1'b1;
      @(posedge clk); #1;
    end
    flush_s[0] = 1'b1;
    a_s[0] = 16'h1234;
    @(posedge clk); #1;
    flush_s[0] = 1'b0;
    vin_s[0] = 1'b0;
    check(g_dut[0].busy === 1'b0, "flush_busy", 64'(g_dut[0].busy), 0);
    check(g_dut[0].vout === 1'b0, "flush_valid", 64'(g_dut[0].vout), 0);
    timed_op(16'h0003, 16'h0005, 1'b0, 4'hA, 32'h0000000F, "post_flush");
    repeat (8) @(posedge clk);
    #1;

    // async reset between edges with the pipe full
    for (int i = 0; i < 6; i++) begin
      a_s[0] = 16'h1111 * 16'(i + 1); b_s[0] = 16'h0203; sgn_s[0] = 1'(i);
      tin_s[0] = 4'(i + 1); vin_s[0] = 1'b1;
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    vin_s[0] = 1'b0;
    #1;
    check(g_dut[0].val == 0, "arst_val", 64'(g_dut[0].val), 0);
    check(g_dut[0].tout == 0, "arst_tag", 64'(g_dut[0].tout), 0);
    check(g_dut[0].vout === 1'b0, "arst_valid", 64'(g_dut[0].vout), 0);
    check(g_dut[0].busy === 1'b0, "arst_busy", 64'(g_dut[0].busy), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check(g_dut[0].rdy === 1'b1, "arst_release_ready", 64'(g_dut[0].rdy), 1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (g_dut[0].vout) seen++;
    end
    check(seen == 0, "arst_no_stale", 64'(seen), 0);
    @(posedge clk); #1;

    // W=8 sweep over all multiplicands against a set of edge multipliers, both modes
    for (int s = 0; s < 2; s++) begin
      for (int bi = 0; bi < 10; bi++) begin
        for (int a = 0; a < 256; a++) begin
          for (int g = 1; g < NDUT; g++) begin
            a_s[g] = 16'(a); b_s[g] = bvals[bi]; sgn_s[g] = 1'(s);
            tin_s[g] = 4'(a); vin_s[g] = 1'b1;
          end
          @(posedge clk); #1;
        end
      end
    end
    for (int g = 1; g < NDUT; g++) vin_s[g] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check(g_dut[1].q.size() == 0, "w8_lps1_drained", 64'(g_dut[1].q.size()), 0);
    check(g_dut[2].q.size() == 0, "w8_lps2_drained", 64'(g_dut[2].q.size()), 0);
    check(g_dut[3].q.size() == 0, "w8_lps4_drained", 64'(g_dut[3].q.size()), 0);
    check(g_dut[0].q.size() == 0, "w16_final_drained", 64'(g_dut[0].q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
